// File: rtl/pi_loop_filter.sv
// Proportional-integral loop filter between the Costas phase detector and the NCO.
// Two-stage pipeline: integrator/proportional registers, then saturated output sum.
module pi_loop_filter #(
   parameter int ERR_W    = 32,
   parameter int OUT_W    = 32,
   parameter int KP_SHIFT = 2,
   parameter int KI_SHIFT = 18,
   parameter int LOCK_THR = 1024,
   parameter int LOCK_CNT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [ERR_W-1:0] phase_error,
   input  logic [OUT_W-1:0] initial_freq,
   input  logic             hold,
   input  logic             clear,
   output logic [OUT_W-1:0] freq_ctrl,
   output logic             freq_valid,
   output logic             sat_flag,
   output logic             locked
);

   localparam int SUM_W = ((ERR_W > OUT_W) ? ERR_W : OUT_W) + 1;
   localparam int CNT_W = $clog2(LOCK_CNT + 1);

   localparam logic signed [SUM_W-1:0] OUT_MAX =
      {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] OUT_MIN =
      {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic [ERR_W:0]     THR     = (ERR_W+1)'(LOCK_THR);
   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(LOCK_CNT);

   logic [OUT_W-1:0] integ;
   logic [ERR_W-1:0] prop_r;
   logic             int_sat_r;
   logic             s1_valid;
   logic [CNT_W-1:0] cnt;

   logic [ERR_W-1:0]        prop_next, inc;
   logic signed [SUM_W-1:0] int_sum, out_sum;
   logic [OUT_W-1:0]        int_next, out_next;
   logic                    int_clamped, out_clamped;
   logic [ERR_W:0]          err_ext, err_mag;
   logic                    in_thr;
   logic [CNT_W-1:0]        cnt_next;

   assign prop_next = $signed(phase_error) >>> KP_SHIFT;
   assign inc       = $signed(phase_error) >>> KI_SHIFT;

   // Sums are formed one bit wider than either operand so overflow is visible before clamping.
   assign int_sum = $signed({{(SUM_W-OUT_W){integ[OUT_W-1]}}, integ})
                  + $signed({{(SUM_W-ERR_W){inc[ERR_W-1]}}, inc});
   assign out_sum = $signed({{(SUM_W-OUT_W){integ[OUT_W-1]}}, integ})
                  + $signed({{(SUM_W-ERR_W){prop_r[ERR_W-1]}}, prop_r});

   always_comb begin
      int_next    = int_sum[OUT_W-1:0];
      int_clamped = 1'b0;
      out_next    = out_sum[OUT_W-1:0];
      out_clamped = 1'b0;
      if (int_sum > OUT_MAX) begin
         int_next    = OUT_MAX[OUT_W-1:0];
         int_clamped = 1'b1;
      end else if (int_sum < OUT_MIN) begin
         int_next    = OUT_MIN[OUT_W-1:0];
         int_clamped = 1'b1;
      end
      if (out_sum > OUT_MAX) begin
         out_next    = OUT_MAX[OUT_W-1:0];
         out_clamped = 1'b1;
      end else if (out_sum < OUT_MIN) begin
         out_next    = OUT_MIN[OUT_W-1:0];
         out_clamped = 1'b1;
      end
   end

   // Magnitude uses one extra bit so the most-negative error maps to 2^(ERR_W-1), never "in".
   assign err_ext = {phase_error[ERR_W-1], phase_error};
   assign err_mag = err_ext[ERR_W] ? (~err_ext + 1'b1) : err_ext;
   assign in_thr  = (err_mag < THR);

   always_comb begin
      cnt_next = '0;
      if (in_thr) cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
   end

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         integ      <= initial_freq;
         prop_r     <= '0;
         int_sat_r  <= 1'b0;
         s1_valid   <= 1'b0;
         cnt        <= '0;
         locked     <= 1'b0;
         freq_ctrl  <= '0;
         freq_valid <= 1'b0;
         sat_flag   <= 1'b0;
      end else if (clear) begin
         integ      <= initial_freq;
         prop_r     <= '0;
         int_sat_r  <= 1'b0;
         s1_valid   <= 1'b0;
         cnt        <= '0;
         locked     <= 1'b0;
         freq_valid <= 1'b0;
         sat_flag   <= 1'b0;
      end else begin
         s1_valid <= valid_in;
         if (valid_in) begin
            prop_r <= prop_next;
            if (!hold) begin
               integ     <= int_next;
               int_sat_r <= int_clamped;
            end else begin
               int_sat_r <= 1'b0;
            end
            cnt    <= cnt_next;
            locked <= (cnt_next == CNT_MAX);
         end
         freq_valid <= s1_valid;
         if (s1_valid) begin
            freq_ctrl <= out_next;
            sat_flag  <= int_sat_r | out_clamped;
         end else begin
            sat_flag  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pi_loop_filter.sv
// Scoreboard bench for pi_loop_filter: directed samples push hand-computed results,
// a negedge monitor pops and compares on every freq_valid pulse.
module tb_pi_loop_filter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_in = 1'b0;
   logic        hold = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] phase_error = '0;
   logic [31:0] initial_freq = '0;
   logic [31:0] freq_ctrl;
   logic        freq_valid, sat_flag, locked;

   int cyc = 0;
   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      int          cyc;
      logic [31:0] freq;
      logic        sat;
   } exp_t;
   exp_t sb[$];

   pi_loop_filter dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .phase_error(phase_error),
      .initial_freq(initial_freq), .hold(hold), .clear(clear),
      .freq_ctrl(freq_ctrl), .freq_valid(freq_valid), .sat_flag(sat_flag), .locked(locked)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every pulse must match the oldest expectation, including its arrival cycle.
   exp_t mon_e;
   always @(negedge clk) begin
      if (freq_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", 64'(freq_valid), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("latency",   64'(cyc),       64'(mon_e.cyc));
            check("freq_ctrl", 64'(freq_ctrl), 64'(mon_e.freq));
            check("sat_flag",  64'(sat_flag),  64'(mon_e.sat));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [31:0] err, input logic h, input logic push,
                       input logic [31:0] ef, input logic es);
      exp_t e;
      valid_in    = 1'b1;
      phase_error = err;
      hold        = h;
      if (push) begin
         e.cyc  = cyc + 2;
         e.freq = ef;
         e.sat  = es;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      hold     = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   initial begin
      // Reset with integrator load value applied
      rst          = 1'b0;
      initial_freq = 32'h1000_0000;
      idle(3);
      check("rst_freq_ctrl",  64'(freq_ctrl),  64'd0);
      check("rst_freq_valid", 64'(freq_valid), 64'd0);
      check("rst_sat_flag",   64'(sat_flag),   64'd0);
      check("rst_locked",     64'(locked),     64'd0);
      rst = 1'b1;
      idle(1);

      send(32'h0, 1'b0, 1'b1, 32'h1000_0000, 1'b0);
      idle(3);

      // Back-to-back: prop 65536 + inc 1, then inc only
      send(32'h0004_0000, 1'b0, 1'b1, 32'h1001_0001, 1'b0);
      send(32'h0,         1'b0, 1'b1, 32'h1000_0001, 1'b0);
      idle(3);

      // Output-only clamp: integrator stays in range
      initial_freq = 32'h7FFF_0000;
      do_clear();
      send(32'h0004_0000, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1);
      send(32'h0,         1'b0, 1'b1, 32'h7FFF_0001, 1'b0);
      idle(3);

      // Integrator saturation, positive then negative
      initial_freq = 32'h7FFF_FFF0;
      do_clear();
      repeat (4) send(32'h4000_0000, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1);
      idle(3);
      initial_freq = 32'h8000_0010;
      do_clear();
      repeat (4) send(32'hC000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b1);
      idle(3);

      // Hold freezes integrator, proportional path stays live
      initial_freq = 32'h1000_0000;
      do_clear();
      send(32'h0004_0000, 1'b1, 1'b1, 32'h1001_0000, 1'b0);
      send(32'h0,         1'b0, 1'b1, 32'h1000_0000, 1'b0);
      send(32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0FFF_FFFE, 1'b0);
      idle(3);

      // Lock detector
      initial_freq = 32'h0;
      do_clear();
      repeat (15) send(32'd100, 1'b0, 1'b1, 32'd25, 1'b0);
      check("locked_after_15", 64'(locked), 64'd0);
      send(32'd100, 1'b0, 1'b1, 32'd25, 1'b0);
      check("locked_after_16", 64'(locked), 64'd1);
      idle(3);
      check("locked_gap", 64'(locked), 64'd1);
      send(32'hFFFF_F830, 1'b0, 1'b1, 32'hFFFF_FE0B, 1'b0);
      check("unlock_out_thr", 64'(locked), 64'd0);

      repeat (15) send(32'd100, 1'b0, 1'b1, 32'h0000_0018, 1'b0);
      send(32'h8000_0000, 1'b0, 1'b1, 32'hDFFF_DFFF, 1'b0);
      check("most_neg_no_lock", 64'(locked), 64'd0);

      repeat (15) send(32'd100, 1'b0, 1'b1, 32'hFFFF_E018, 1'b0);
      send(32'd1024, 1'b0, 1'b1, 32'hFFFF_E0FF, 1'b0);
      check("thr_exact_no_lock", 64'(locked), 64'd0);

      repeat (15) send(32'd100, 1'b0, 1'b1, 32'hFFFF_E018, 1'b0);
      send(32'd1023, 1'b0, 1'b1, 32'hFFFF_E0FE, 1'b0);
      check("thr_below_lock", 64'(locked), 64'd1);
      idle(3);

      // Clear one cycle after an accepted sample cancels it
      initial_freq = 32'h1000_0000;
      send(32'h0004_0000, 1'b0, 1'b0, 32'h0, 1'b0);
      do_clear();
      check("clr_no_pulse",  64'(freq_valid), 64'd0);
      check("clr_hold_freq", 64'(freq_ctrl),  64'hFFFF_E0FE);
      check("clr_unlock",    64'(locked),     64'd0);

      // Clear together with valid_in drops the sample
      clear = 1'b1;
      send(32'h0004_0000, 1'b0, 1'b0, 32'h0, 1'b0);
      clear = 1'b0;
      send(32'h0, 1'b0, 1'b1, 32'h1000_0000, 1'b0);
      idle(3);

      // Reset mid-stream discards the in-flight sample
      initial_freq = 32'h2000_0000;
      send(32'h0004_0000, 1'b0, 1'b0, 32'h0, 1'b0);
      rst = 1'b0;
      idle(1);
      check("mid_rst_freq_ctrl",  64'(freq_ctrl),  64'd0);
      check("mid_rst_freq_valid", 64'(freq_valid), 64'd0);
      check("mid_rst_sat_flag",   64'(sat_flag),   64'd0);
      check("mid_rst_locked",     64'(locked),     64'd0);
      rst = 1'b1;
      send(32'h0, 1'b0, 1'b1, 32'h2000_0000, 1'b0);
      idle(4);

      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end

endmodule

// File: doc/pi_loop_filter.md
Name: pi_loop_filter

Overview:
Parametrised proportional-integral loop filter for the Costas loop carrier-recovery chain. It sits between the phase detector and the NCO. Each accepted phase-error sample produces a new frequency control word. The word carries the integrator state plus a proportional term, with saturating arithmetic, integrator hold/clear controls and a registered lock indicator.

Parameters:
ERR_W, 32, phase_error width (signed)
OUT_W, 32, freq_ctrl / initial_freq / integrator range width (signed)
KP_SHIFT, 2, proportional gain as arithmetic right shift (gain 2^-KP_SHIFT), range 0..ERR_W-1
KI_SHIFT, 18, integral gain as arithmetic right shift, range 0..ERR_W-1
LOCK_THR, 1024, lock threshold on |phase_error| (strictly less than = "in lock")
LOCK_CNT, 16, consecutive in-threshold samples required to assert locked, >=1

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
valid_in  in  1  phase_error qualifier; may be high every cycle
phase_error  in  ERR_W  signed phase-detector output
initial_freq  in  OUT_W  signed integrator load value (reset and clear)
hold  in  1  freeze integrator; proportional path still active
clear  in  1  synchronous integrator reload, cancels in-flight sample
freq_ctrl  out  OUT_W  signed NCO frequency control word
freq_valid  out  1  one-cycle pulse, freq_ctrl updated
sat_flag  out  1  qualified by freq_valid: integrator or output clamped for this sample
locked  out  1  lock indicator

Behaviour:
- Reset (rst=0 at posedge clk): integrator <= initial_freq (sampled that edge), prop_r <= 0, stage valid <= 0, lock counter <= 0. freq_ctrl=0, freq_valid=0, sat_flag=0, locked=0. Reset overrides all inputs, including mid-stream; in-flight samples are discarded.
- Shifts are arithmetic (floor toward -inf), e.g. -1>>>2 = -1. Operands are sign-extended to OUT_W+1 bits before addition. No intermediate wrap is permitted.
- Stage 1, edge after valid_in=1 at cycle T:
  - prop_r <= phase_error>>>KP_SHIFT.
  - If hold=0: integrator <= clamp(integrator + (phase_error>>>KI_SHIFT)) to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and int_sat_r <= clamp occurred.
  - If hold=1: integrator is unchanged and int_sat_r <= 0.
  - s1_valid <= 1.
- Stage 2, edge T+2: freq_ctrl <= clamp(integrator + prop_r), using the values registered at T+1. freq_valid <= 1 for one cycle. sat_flag <= int_sat_r OR output clamp.
- Latency is 2 cycles. Throughput is 1 sample/cycle. Back-to-back samples are handled independently.
- Without a new sample, freq_ctrl holds its value. freq_valid=0 and sat_flag=0 when freq_valid=0.
- Clear (rst=1, clear=1): integrator <= initial_freq, prop_r <= 0, s1_valid <= 0, lock counter <= 0, locked <= 0.
  - freq_ctrl holds and no freq_valid pulse occurs for a sample accepted at T when clear is asserted at T or T+1.
  - clear wins over a simultaneous valid_in, so that sample is dropped.
  - clear wins over hold.
- Lock detector, updated at T+1 per accepted sample:
  - in = (|phase_error| < LOCK_THR). The most-negative ERR_W value counts as out of threshold.
  - If in: counter <= min(counter+1, LOCK_CNT). Otherwise counter <= 0.
  - locked <= (next counter == LOCK_CNT). A single out-of-threshold sample deasserts locked at T+1.
  - Counter width is clog2(LOCK_CNT+1). The counter saturates and never wraps.
- hold has no effect on the lock detector.

Test Plan:
- Default params, rst low with initial_freq=0x1000_0000, release, then valid err=0 -> freq_ctrl=0x1000_0000 with freq_valid high exactly 2 cycles later for one cycle; sat_flag=0.
- err=0x0004_0000 then err=0 on back-to-back cycles -> freq_ctrl 0x1001_0001 then 0x1000_0001 on consecutive cycles (prop 65536, inc 1).
- initial_freq=0x7FFF_FFF0, err=0x4000_0000 for 4 samples -> integrator clamps at 0x7FFF_FFFF, freq_ctrl=0x7FFF_FFFF, sat_flag=1 on every pulse; negative mirror with err=0xC000_0000 -> 0x8000_0000.
- hold=1, err=0x0004_0000 -> freq_ctrl=init+0x0001_0000; then hold=0, err=0 -> freq_ctrl=init (integrator unchanged); err=-1 -> freq_ctrl=init-2 (prop -1, inc -1).
- LOCK_THR=1024, LOCK_CNT=16: 15 samples err=100 -> locked=0; 16th -> locked=1 at T+1; gap cycles keep locked; err=-2000 -> locked=0 next cycle; err=0x8000_0000 never counts.
- valid at T with clear at T+1 -> no freq_valid at T+2, next err=0 sample gives freq_ctrl=initial_freq; rst low one cycle mid-stream -> all outputs 0 next edge, pipeline empty, integrator=initial_freq.
